// File: rtl/median_filter_rank.sv
// median_filter_rank: streaming rank-order filter over a sliding window of the
// last WIN accepted samples. The window feeds a registered odd-even
// transposition sorter, and the output picks the element at the rank that was
// sampled together with each input sample.
module median_filter_rank #(
  parameter int unsigned WIN       = 9,
  parameter int unsigned DW        = 8,
  parameter int unsigned RW        = $clog2(WIN),
  parameter int unsigned FILL_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] dat_i,
  input  logic          val_i,
  input  logic [RW-1:0] rank_i,
  output logic [DW-1:0] dat_o,
  output logic          val_o
);

  localparam int unsigned   CW    = $clog2(WIN + 1);
  localparam logic [RW-1:0] RMAX  = RW'(WIN - 1);
  localparam logic [CW-1:0] CSAT  = CW'(WIN);
  localparam logic [CW-1:0] CFULL = CW'(WIN - 1);

  typedef logic [WIN-1:0][DW-1:0] vec_t;

  vec_t          win_q, win_d;
  vec_t          stg_q [WIN+1];
  vec_t          stg_d [WIN+1];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIN+1:0] v_q;
  logic [RW-1:0] rk_q [WIN+2];
  logic [RW-1:0] rk_in;
  logic          v_in;
  logic [DW-1:0] dat_q;
  logic          val_q;

  // Window shift, fill count, rank clamp and the valid bit for the new sample.
  always_comb begin
    win_d = win_q;
    cnt_d = cnt_q;
    if (val_i) begin
      win_d = {win_q[WIN-2:0], dat_i};
      if (cnt_q != CSAT) cnt_d = cnt_q + 1'b1;
    end
    rk_in = (rank_i > RMAX) ? RMAX : rank_i;
    // cnt_q still excludes the current sample, so WIN-1 means this one fills it
    v_in  = val_i & ((FILL_MODE == 0) | (cnt_q >= CFULL));
  end

  // Window, fill counter and the rank/valid side pipeline (advances every cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      cnt_q <= '0;
      v_q   <= '0;
      for (int unsigned j = 0; j < WIN + 2; j++) rk_q[j] <= '0;
    end else begin
      win_q <= win_d;
      cnt_q <= cnt_d;
      v_q   <= {v_q[WIN:0], v_in};
      rk_q[0] <= rk_in;
      for (int unsigned j = 1; j < WIN + 2; j++) rk_q[j] <= rk_q[j-1];
    end
  end

  // Compare-exchange network: stage s uses even pairs when s is even, odd otherwise.
  always_comb begin
    stg_d[0] = win_q;
    for (int unsigned s = 0; s < WIN; s++) begin
      stg_d[s+1] = stg_q[s];
      for (int unsigned i = 0; i + 1 < WIN; i++) begin
        if ((i % 2) == (s % 2) && stg_q[s][i] > stg_q[s][i+1]) begin
          stg_d[s+1][i]   = stg_q[s][i+1];
          stg_d[s+1][i+1] = stg_q[s][i];
        end
      end
    end
  end

  // Snapshot register plus WIN sort stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < WIN + 1; s++) stg_q[s] <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  // Output register: select the sample's rank; data holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_q <= '0;
      val_q <= 1'b0;
    end else begin
      val_q <= v_q[WIN+1];
      if (v_q[WIN+1]) dat_q <= stg_q[WIN][rk_q[WIN+1]];
    end
  end

  assign dat_o = dat_q;
  assign val_o = val_q;

endmodule

// File: tb/tb_median_filter_rank.sv
// Bench for median_filter_rank: two instances (FILL_MODE 0 and 1) share the
// same stimulus and are compared every cycle against a sort-based window model.
module tb_median_filter_rank;

  localparam int WIN = 9;
  localparam int DW  = 8;
  localparam int RW  = $clog2(WIN);
  localparam int LAT = WIN + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dat_i;
  logic          val_i;
  logic [RW-1:0] rank_i;
  logic [DW-1:0] d0, d1;
  logic          v0, v1;

  always #5 clk = ~clk;

  median_filter_rank #(.WIN(WIN), .DW(DW), .RW(RW), .FILL_MODE(0)) u0 (
    .clk(clk), .rst(rst), .dat_i(dat_i), .val_i(val_i), .rank_i(rank_i),
    .dat_o(d0), .val_o(v0)
  );

  median_filter_rank #(.WIN(WIN), .DW(DW), .RW(RW), .FILL_MODE(1)) u1 (
    .clk(clk), .rst(rst), .dat_i(dat_i), .val_i(val_i), .rank_i(rank_i),
    .dat_o(d1), .val_o(v1)
  );

  typedef struct { int due; int val; } exp_t;

  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;
  int   hist[$];
  exp_t sb0[$];
  exp_t sb1[$];
  int   last0 = 0;
  int   last1 = 0;
  int   pulses0 = 0;
  int   pulses1 = 0;
  int   pcyc[$];
  int   samp[9] = '{10, 200, 30, 40, 50, 60, 70, 80, 90};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference: zero-padded window of the last WIN samples, sorted, rank clamped.
  function automatic int ref_val(input int rank);
    int w[$];
    for (int i = hist.size(); i < WIN; i++) w.push_back(0);
    foreach (hist[i]) w.push_back(hist[i]);
    w.sort();
    return w[(rank >= WIN) ? WIN - 1 : rank];
  endfunction

  task automatic step(input logic r, input logic v, input int d, input int rk);
    exp_t t;
    rst    = r;
    val_i  = v;
    dat_i  = d[DW-1:0];
    rank_i = rk[RW-1:0];
    @(posedge clk);
    cyc++;
    if (r) begin
      hist.delete(); sb0.delete(); sb1.delete();
      last0 = 0; last1 = 0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > WIN) void'(hist.pop_front());
      t.due = cyc + LAT;
      t.val = ref_val(rk);
      sb0.push_back(t);
      if (hist.size() == WIN) sb1.push_back(t);
    end
    #1;
    if (v0 === 1'b1) begin pulses0++; pcyc.push_back(cyc); end
    if (v1 === 1'b1) pulses1++;
    if (sb0.size() > 0 && sb0[0].due == cyc) begin
      t = sb0.pop_front();
      check("val0", v0, 1);
      check("dat0", d0, t.val);
      last0 = t.val;
    end else begin
      check("val0_idle", v0, 0);
      check("dat0_hold", d0, last0);
    end
    if (sb1.size() > 0 && sb1[0].due == cyc) begin
      t = sb1.pop_front();
      check("val1", v1, 1);
      check("dat1", d1, t.val);
      last1 = t.val;
    end else begin
      check("val1_idle", v1, 0);
      check("dat1_hold", d1, last1);
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4);
  endtask

  initial begin
    rst = 1'b1; val_i = 1'b0; dat_i = '0; rank_i = '0;

    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_dat0", d0, 0);
    check("reset_val0", v0, 0);

    // median ordering, back-to-back
    foreach (samp[i]) step(0, 1, samp[i], 4);
    flush(LAT + 1);
    check("median_final", d0, 60);

    // rank select: min, max, clamped out-of-range rank
    step(0, 1, 90, 0);
    step(0, 1, 90, 8);
    step(0, 1, 90, 15);
    flush(LAT + 1);
    check("rank_clamp_final", d0, 90);

    // gapped input
    step(1, 0, 0, 0);
    pulses0 = 0; pcyc.delete();
    foreach (samp[i]) begin
      step(0, 1, samp[i], 4);
      if (i != 8) begin
        step(0, 0, 0, 4); step(0, 0, 0, 4); step(0, 0, 0, 4);
      end
    end
    flush(LAT + 1);
    check("gap_pulses", pulses0, 9);
    for (int i = 1; i < pcyc.size(); i++) check("gap_spacing", pcyc[i] - pcyc[i-1], 4);
    check("gap_final", d0, 60);

    // warm-up
    step(1, 0, 0, 0);
    pulses1 = 0;
    for (int i = 1; i <= 12; i++) step(0, 1, i, 4);
    flush(LAT + 1);
    check("warm_pulses", pulses1, 4);
    check("warm_final", d1, 8);

    // reset mid-stream
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        step(1, 1, $urandom_range(0, 255), 4);
        check("mid_rst_dat0", d0, 0);
        check("mid_rst_val1", v1, 0);
      end else begin
        step(0, 1, $urandom_range(0, 255), 4);
      end
    end
    flush(LAT + 1);

    // ties and extremes
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 255, 4);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 4);
    flush(LAT + 1);
    check("ties_final", d0, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 255), $urandom_range(0, 15));
    end
    flush(LAT + 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
